// File: rtl/adder_4bit.sv
// Registered ripple-carry adder: one operand set per cycle, result one cycle later,
// with unsigned carry, signed overflow and zero flags.
module adder_4bit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    input  logic             carryin,
    output logic             carryout,
    input  logic             in_valid,
    output logic             out_valid,
    output logic             overflow,
    output logic             zero
);

    // Result is packed as {carry out of MSB, carry into MSB, sum}.
    function automatic logic [WIDTH+1:0] ripple_add(
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y,
        input logic             cin
    );
        logic [WIDTH-1:0] s;
        logic             c;
        logic             c_msb;
        s     = '0;
        c     = cin;
        c_msb = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            s[i] = x[i] ^ y[i] ^ c;
            if (i == WIDTH - 1)
                c_msb = c;
            c = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        return {c, c_msb, s};
    endfunction

    function automatic logic signed_overflow(input logic c_msb, input logic c_out);
        return c_msb ^ c_out;
    endfunction

    logic [WIDTH+1:0] add_p0;
    logic [WIDTH-1:0] sum_p0;
    logic             cout_p0;
    logic             ovf_p0;
    logic             zero_p0;

    logic [WIDTH-1:0] sum_p1;
    logic             cout_p1;
    logic             ovf_p1;
    logic             zero_p1;
    logic             vld_p1;

    // Stage p0: combinational add of the presented operands
    always_comb begin
        add_p0  = ripple_add(a, b, carryin);
        sum_p0  = add_p0[WIDTH-1:0];
        cout_p0 = add_p0[WIDTH+1];
        ovf_p0  = signed_overflow(add_p0[WIDTH], add_p0[WIDTH+1]);
        zero_p0 = (sum_p0 == '0);
    end

    // Stage p1: result registers load only on valid input, so idle-cycle inputs never reach state
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_p1  <= '0;
            cout_p1 <= 1'b0;
            ovf_p1  <= 1'b0;
            zero_p1 <= 1'b0;
            vld_p1  <= 1'b0;
        end else begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                sum_p1  <= sum_p0;
                cout_p1 <= cout_p0;
                ovf_p1  <= ovf_p0;
                zero_p1 <= zero_p0;
            end
        end
    end

    assign sum       = sum_p1;
    assign carryout  = cout_p1;
    assign overflow  = ovf_p1;
    assign zero      = zero_p1;
    assign out_valid = vld_p1;

endmodule

// File: tb/tb_adder_4bit.sv
// Bench for adder_4bit: directed vector table, multi-cycle sequences,
// exhaustive sweep and a randomized stream against an arithmetic model.
module tb_adder_4bit;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] a, b, sum;
    logic             carryin, carryout, in_valid, out_valid, overflow, zero;

    int n_cmp = 0;
    int n_bad = 0;

    adder_4bit #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .sum(sum), .carryin(carryin),
        .carryout(carryout), .in_valid(in_valid), .out_valid(out_valid),
        .overflow(overflow), .zero(zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        int a, b, cin;
        int sum, cout, ovf, zero;
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference from plain integer arithmetic on unsigned and signed views.
    function automatic void model(input int x, input int y, input int c,
                                  output int s, output int co, output int ov, output int z);
        int t, ss;
        t  = x + y + c;
        ss = (x > 7 ? x - 16 : x) + (y > 7 ? y - 16 : y) + c;
        s  = t % 16;
        co = t / 16;
        ov = (ss > 7 || ss < -8) ? 1 : 0;
        z  = (s == 0) ? 1 : 0;
    endfunction

    task automatic drive(input int x, input int y, input int c, input bit v);
        a = x[WIDTH-1:0]; b = y[WIDTH-1:0]; carryin = c[0]; in_valid = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string nm, input int s, input int co, input int ov,
                           input int z, input int v);
        chk({nm, ".sum"}, int'(sum), s);
        chk({nm, ".carryout"}, int'(carryout), co);
        chk({nm, ".overflow"}, int'(overflow), ov);
        chk({nm, ".zero"}, int'(zero), z);
        chk({nm, ".out_valid"}, int'(out_valid), v);
    endtask

    vec_t tbl[8];
    int   es, eco, eov, ez, ev;
    int   ra, rb, rc;
    bit   rv;

    initial begin
        tbl[0] = '{a:10, b:13, cin:1, sum:8,  cout:1, ovf:0, zero:0};
        tbl[1] = '{a:14, b:9,  cin:0, sum:7,  cout:1, ovf:1, zero:0};
        tbl[2] = '{a:7,  b:1,  cin:0, sum:8,  cout:0, ovf:1, zero:0};
        tbl[3] = '{a:0,  b:0,  cin:0, sum:0,  cout:0, ovf:0, zero:1};
        tbl[4] = '{a:15, b:15, cin:1, sum:15, cout:1, ovf:0, zero:0};
        tbl[5] = '{a:15, b:0,  cin:1, sum:0,  cout:1, ovf:0, zero:1};
        tbl[6] = '{a:7,  b:7,  cin:1, sum:15, cout:0, ovf:1, zero:0};
        tbl[7] = '{a:8,  b:8,  cin:0, sum:0,  cout:1, ovf:1, zero:1};

        rst = 1'b1;
        drive(0, 0, 0, 1'b0);
        tick();
        tick();
        chk_all("reset", 0, 0, 0, 0, 0);

        // Idle cycle after reset release keeps outputs at zero
        rst = 1'b0;
        drive(5, 6, 1, 1'b0);
        tick();
        chk_all("post_reset_idle", 0, 0, 0, 0, 0);

        foreach (tbl[i]) begin
            drive(tbl[i].a, tbl[i].b, tbl[i].cin, 1'b1);
            tick();
            chk_all($sformatf("vec%0d", i), tbl[i].sum, tbl[i].cout, tbl[i].ovf, tbl[i].zero, 1);
        end

        // Back-to-back operands, then idle: valid drops, data holds
        drive(3, 4, 0, 1'b1); tick();
        chk_all("b2b0", 7, 0, 0, 0, 1);
        drive(9, 9, 1, 1'b1); tick();
        chk_all("b2b1", 3, 1, 1, 0, 1);
        drive(12, 4, 0, 1'b1); tick();
        chk_all("b2b2", 0, 1, 0, 1, 1);
        drive(1, 2, 1, 1'b0); tick();
        chk_all("hold0", 0, 1, 0, 1, 0);
        drive(6, 6, 0, 1'b0); tick();
        chk_all("hold1", 0, 1, 0, 1, 0);

        // Load a nonzero result, then reset on the same edge as a valid operand
        drive(15, 15, 1, 1'b1); tick();
        chk_all("pre_rst", 15, 1, 0, 0, 1);
        rst = 1'b1;
        drive(7, 1, 0, 1'b1); tick();
        chk_all("rst_vs_valid", 0, 0, 0, 0, 0);
        rst = 1'b0;
        drive(7, 1, 0, 1'b1); tick();
        chk_all("after_rst", 8, 0, 1, 0, 1);

        // Exhaustive sweep at full throughput
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                for (int c = 0; c < 2; c++) begin
                    drive(x, y, c, 1'b1);
                    tick();
                    model(x, y, c, es, eco, eov, ez);
                    chk($sformatf("sweep_%0d_%0d_%0d.cs", x, y, c),
                        int'({carryout, sum}), x + y + c);
                    chk($sformatf("sweep_%0d_%0d_%0d.ovf", x, y, c), int'(overflow), eov);
                    chk($sformatf("sweep_%0d_%0d_%0d.zero", x, y, c), int'(zero), ez);
                end

        // Random stream with gaps; model holds last result across idle cycles
        model(15, 15, 1, es, eco, eov, ez);
        for (int n = 0; n < 300; n++) begin
            ra = int'($urandom_range(0, 15));
            rb = int'($urandom_range(0, 15));
            rc = int'($urandom_range(0, 1));
            rv = ($urandom_range(0, 3) != 0);
            drive(ra, rb, rc, rv);
            tick();
            if (rv)
                model(ra, rb, rc, es, eco, eov, ez);
            ev = rv ? 1 : 0;
            chk_all($sformatf("rand%0d", n), es, eco, eov, ez, ev);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
